ipbase_intf_axi_arbit_nto1_rd_chn_v1p0: RTL and testbench

Parametrised N-to-1 AXI4 read-channel arbiter with round-robin AR arbitration, a per-slave outstanding-transaction limit, and ID-prefix based R routing. It sits between NUM_SLV read clients and one shared AXI4 read master port, for example a DDR/HBM controller. It generalises the fixed 2-to-1 simplified arbiter to any slave count. The master side is fully registered on AR, and responses are routed back combinationally.

---
 rtl/ipbase_intf_axi_arbit_nto1_rd_chn_v1p0.sv | 262 ++++++++++++++++++++++++++
 tb/tb_ipbase_intf_axi_arbit_nto1_rd_chn_v1p0.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipbase_intf_axi_arbit_nto1_rd_chn_v1p0.sv
// N-to-1 AXI4 read-channel arbiter: round-robin AR arbitration with a
// per-slave outstanding-burst limit, registered AR towards the master and
// combinational R routing by master-ID prefix {slave index, slave id}.
// Optional debug counters are built when IPBASE_ARB_DFX_EN is defined;
// without it dfx_sta0/dfx_sta1 read as zero.
module ipbase_intf_axi_arbit_nto1_rd_chn_v1p0 #(
    parameter int unsigned NUM_SLV    = 4,
    parameter int unsigned SID_W      = 4,
    parameter int unsigned IDX_W      = $clog2(NUM_SLV),
    parameter int unsigned MID_W      = SID_W + IDX_W,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 512,
    parameter logic [2:0]  AXI_SIZE   = 3'b110,
    parameter int unsigned MAX_OUTSTD = 8
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    // slave-side AR
    input  logic [NUM_SLV*SID_W-1:0]    s_axi_arid,
    input  logic [NUM_SLV*ADDR_W-1:0]   s_axi_araddr,
    input  logic [NUM_SLV*8-1:0]        s_axi_arlen,
    input  logic [NUM_SLV-1:0]          s_axi_arvalid,
    output logic [NUM_SLV-1:0]          s_axi_arready,
    // slave-side R
    output logic [NUM_SLV*SID_W-1:0]    s_axi_rid,
    output logic [NUM_SLV*DATA_W-1:0]   s_axi_rdata,
    output logic [NUM_SLV*2-1:0]        s_axi_rresp,
    output logic [NUM_SLV-1:0]          s_axi_rlast,
    output logic [NUM_SLV-1:0]          s_axi_rvalid,
    input  logic [NUM_SLV-1:0]          s_axi_rready,
    // master-side AR
    output logic [MID_W-1:0]            m_axi_arid,
    output logic [ADDR_W-1:0]           m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arlock,
    output logic [3:0]                  m_axi_arcache,
    output logic [2:0]                  m_axi_arprot,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    // master-side R
    input  logic [MID_W-1:0]            m_axi_rid,
    input  logic [DATA_W-1:0]           m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    // debug
    input  logic [31:0]                 dfx_cfg0,
    output logic [31:0]                 dfx_sta0,
    output logic [31:0]                 dfx_sta1
);

    localparam int unsigned OW    = $clog2(MAX_OUTSTD + 1);
    localparam int unsigned IDX_N = 1 << IDX_W;
    // prefixes that map to a real slave port
    localparam logic [IDX_N-1:0] SLOT_OK = IDX_N'((1 << NUM_SLV) - 1);

    logic [NUM_SLV-1:0] elig;
    logic [NUM_SLV-1:0] grant;
    logic               grant_any;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic               accept;
    logic [IDX_W-1:0]   rr_ptr;
    logic [OW-1:0]      outstd [NUM_SLV];

    logic               ar_valid;
    logic [MID_W-1:0]   ar_id;
    logic [ADDR_W-1:0]  ar_addr;
    logic [7:0]         ar_len;
    logic [SID_W-1:0]   nxt_sid;
    logic [ADDR_W-1:0]  nxt_addr;
    logic [7:0]         nxt_len;

    logic [IDX_W-1:0]   r_idx;
    logic               r_mapped;
    logic [NUM_SLV-1:0] r_sel;
    logic               r_last_hs;

    // AR register can take a new burst when empty or draining this cycle
    assign accept = !ar_valid || m_axi_arready;

    // Eligibility: requesting and below the outstanding limit; nothing during reset
    always_comb begin
        elig = '0;
        for (int unsigned k = 0; k < NUM_SLV; k++) begin
            elig[k] = s_axi_arvalid[k] && (outstd[k] < OW'(MAX_OUTSTD)) && !sys_rst;
        end
    end

    // Round-robin search starting after the last granted slave
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        if (accept) begin
            for (int unsigned i = 1; i <= NUM_SLV; i++) begin
                cand = IDX_W'((32'(rr_ptr) + i) % NUM_SLV);
                if (!grant_any && elig[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                    grant[cand] = 1'b1;
                end
            end
        end
    end

    assign s_axi_arready = grant;

    // Select the granted slave's AR fields
    always_comb begin
        nxt_sid  = '0;
        nxt_addr = '0;
        nxt_len  = '0;
        for (int unsigned k = 0; k < NUM_SLV; k++) begin
            if (grant[k]) begin
                nxt_sid  = s_axi_arid[k*SID_W +: SID_W];
                nxt_addr = s_axi_araddr[k*ADDR_W +: ADDR_W];
                nxt_len  = s_axi_arlen[k*8 +: 8];
            end
        end
    end

    // AR output register and round-robin pointer
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ar_valid <= 1'b0;
            ar_id    <= '0;
            ar_addr  <= '0;
            ar_len   <= '0;
            rr_ptr   <= IDX_W'(NUM_SLV - 1);
        end else if (grant_any) begin
            ar_valid <= 1'b1;
            ar_id    <= {grant_idx, nxt_sid};
            ar_addr  <= nxt_addr;
            ar_len   <= nxt_len;
            rr_ptr   <= grant_idx;
        end else if (m_axi_arready) begin
            ar_valid <= 1'b0;
        end
    end

    assign m_axi_arvalid = ar_valid;
    assign m_axi_arid    = ar_id;
    assign m_axi_araddr  = ar_addr;
    assign m_axi_arlen   = ar_len;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;

    // R routing by ID prefix; unmapped prefixes are sunk
    assign r_idx    = m_axi_rid[MID_W-1:SID_W];
    assign r_mapped = SLOT_OK[r_idx];

    always_comb begin
        r_sel = '0;
        for (int unsigned k = 0; k < NUM_SLV; k++) begin
            r_sel[k] = (r_idx == IDX_W'(k));
        end
    end

    assign s_axi_rvalid = r_sel & {NUM_SLV{m_axi_rvalid}};
    assign m_axi_rready = r_mapped ? |(r_sel & s_axi_rready) : 1'b1;
    assign r_last_hs    = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    // R payload is broadcast; only the addressed slave sees rvalid
    for (genvar k = 0; k < NUM_SLV; k++) begin : g_fan
        assign s_axi_rid[k*SID_W +: SID_W]    = m_axi_rid[SID_W-1:0];
        assign s_axi_rdata[k*DATA_W +: DATA_W] = m_axi_rdata;
        assign s_axi_rresp[k*2 +: 2]          = m_axi_rresp;
        assign s_axi_rlast[k]                 = m_axi_rlast;
    end

    // Outstanding-burst counters: AR handshake adds, RLAST handshake retires
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int unsigned k = 0; k < NUM_SLV; k++) begin
                outstd[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_SLV; k++) begin
                if (grant[k] && !(r_last_hs && r_sel[k]) && (outstd[k] != '1)) begin
                    outstd[k] <= outstd[k] + OW'(1);
                end else if (!grant[k] && r_last_hs && r_sel[k] && (outstd[k] != '0)) begin
                    outstd[k] <= outstd[k] - OW'(1);
                end
            end
        end
    end

`ifdef IPBASE_ARB_DFX_EN
    logic [15:0]    ar_cnt    [NUM_SLV];
    logic [15:0]    rlast_cnt [NUM_SLV];
    logic [15:0]    unmapped_cnt;
    logic [2:0]     dfx_sel;
    logic [15:0]    sel_ar;
    logic [15:0]    sel_rl;
    logic [7:0]     sel_os;
    logic           unused_dfx;

    assign dfx_sel    = dfx_cfg0[6:4];
    assign unused_dfx = ^{dfx_cfg0[31:7], dfx_cfg0[3:1]};

    // Saturating debug counters, cleared by reset or dfx_cfg0[0]
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int unsigned k = 0; k < NUM_SLV; k++) begin
                ar_cnt[k]    <= '0;
                rlast_cnt[k] <= '0;
            end
            unmapped_cnt <= '0;
        end else if (dfx_cfg0[0]) begin
            for (int unsigned k = 0; k < NUM_SLV; k++) begin
                ar_cnt[k]    <= '0;
                rlast_cnt[k] <= '0;
            end
            unmapped_cnt <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_SLV; k++) begin
                if (grant[k] && (ar_cnt[k] != '1)) begin
                    ar_cnt[k] <= ar_cnt[k] + 16'd1;
                end
                if (r_last_hs && r_sel[k] && (rlast_cnt[k] != '1)) begin
                    rlast_cnt[k] <= rlast_cnt[k] + 16'd1;
                end
            end
            if (m_axi_rvalid && !r_mapped && (unmapped_cnt != '1)) begin
                unmapped_cnt <= unmapped_cnt + 16'd1;
            end
        end
    end

    // Status read-back of the selected slave; out-of-range selects read 0
    always_comb begin
        sel_ar = '0;
        sel_rl = '0;
        sel_os = '0;
        for (int unsigned k = 0; k < NUM_SLV; k++) begin
            if (dfx_sel == 3'(k)) begin
                sel_ar = ar_cnt[k];
                sel_rl = rlast_cnt[k];
                sel_os = 8'(outstd[k]);
            end
        end
    end

    assign dfx_sta0 = {sel_ar, sel_rl};
    assign dfx_sta1 = {8'd0, sel_os, unmapped_cnt};
`else
    logic unused_dfx;

    assign unused_dfx = ^dfx_cfg0;
    assign dfx_sta0   = 32'd0;
    assign dfx_sta1   = 32'd0;
`endif

endmodule

// File: tb/tb_ipbase_intf_axi_arbit_nto1_rd_chn_v1p0.sv
// Bench for the N-to-1 AXI read arbiter: a behavioural model checked every
// cycle plus directed scenarios with literal expectations.
module tb_ipbase_intf_axi_arbit_nto1_rd_chn_v1p0;

    localparam int NS = 4;
    localparam int SW = 4;
    localparam int IW = 2;
    localparam int MW = SW + IW;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;
    localparam int N3 = 3;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    // main DUT signals
    logic [SW-1:0]    arid_a [NS];
    logic [AW-1:0]    addr_a [NS];
    logic [7:0]       len_a  [NS];
    logic [NS*SW-1:0] s_arid;
    logic [NS*AW-1:0] s_araddr;
    logic [NS*8-1:0]  s_arlen;
    logic [NS-1:0]    s_arvalid, s_arready;
    logic [NS*SW-1:0] s_rid;
    logic [NS*DW-1:0] s_rdata;
    logic [NS*2-1:0]  s_rresp;
    logic [NS-1:0]    s_rlast, s_rvalid, s_rready;
    logic [MW-1:0]    m_arid;
    logic [AW-1:0]    m_araddr;
    logic [7:0]       m_arlen;
    logic [2:0]       m_arsize, m_arprot;
    logic [1:0]       m_arburst;
    logic             m_arlock;
    logic [3:0]       m_arcache;
    logic             m_arvalid, m_arready;
    logic [MW-1:0]    m_rid;
    logic [DW-1:0]    m_rdata;
    logic [1:0]       m_rresp;
    logic             m_rlast, m_rvalid, m_rready;
    logic [31:0]      dfx_cfg0, dfx_sta0, dfx_sta1;

    // 3-slave instance used for the unmapped-prefix case
    logic [N3*SW-1:0] u3_s_arid;
    logic [N3*AW-1:0] u3_s_araddr;
    logic [N3*8-1:0]  u3_s_arlen;
    logic [N3-1:0]    u3_s_arvalid, u3_s_arready;
    logic [N3*SW-1:0] u3_s_rid;
    logic [N3*DW-1:0] u3_s_rdata;
    logic [N3*2-1:0]  u3_s_rresp;
    logic [N3-1:0]    u3_s_rlast, u3_s_rvalid, u3_s_rready;
    logic [MW-1:0]    u3_m_arid;
    logic [AW-1:0]    u3_m_araddr;
    logic [7:0]       u3_m_arlen;
    logic [2:0]       u3_m_arsize, u3_m_arprot;
    logic [1:0]       u3_m_arburst;
    logic             u3_m_arlock;
    logic [3:0]       u3_m_arcache;
    logic             u3_m_arvalid;
    logic [MW-1:0]    u3_m_rid;
    logic             u3_m_rlast, u3_m_rvalid, u3_m_rready;
    logic [31:0]      u3_dfx_sta0, u3_dfx_sta1;

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            s_arid[k*SW +: SW]   = arid_a[k];
            s_araddr[k*AW +: AW] = addr_a[k];
            s_arlen[k*8 +: 8]    = len_a[k];
        end
    end

    ipbase_intf_axi_arbit_nto1_rd_chn_v1p0 #(
        .NUM_SLV(NS), .SID_W(SW), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTD(MO)
    ) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
        .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
        .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp),
        .s_axi_rlast(s_rlast), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock),
        .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot),
        .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
        .m_axi_rlast(m_rlast), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
        .dfx_cfg0(dfx_cfg0), .dfx_sta0(dfx_sta0), .dfx_sta1(dfx_sta1)
    );

    ipbase_intf_axi_arbit_nto1_rd_chn_v1p0 #(
        .NUM_SLV(N3), .SID_W(SW), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTD(MO)
    ) u_dut3 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .s_axi_arid(u3_s_arid), .s_axi_araddr(u3_s_araddr), .s_axi_arlen(u3_s_arlen),
        .s_axi_arvalid(u3_s_arvalid), .s_axi_arready(u3_s_arready),
        .s_axi_rid(u3_s_rid), .s_axi_rdata(u3_s_rdata), .s_axi_rresp(u3_s_rresp),
        .s_axi_rlast(u3_s_rlast), .s_axi_rvalid(u3_s_rvalid), .s_axi_rready(u3_s_rready),
        .m_axi_arid(u3_m_arid), .m_axi_araddr(u3_m_araddr), .m_axi_arlen(u3_m_arlen),
        .m_axi_arsize(u3_m_arsize), .m_axi_arburst(u3_m_arburst), .m_axi_arlock(u3_m_arlock),
        .m_axi_arcache(u3_m_arcache), .m_axi_arprot(u3_m_arprot),
        .m_axi_arvalid(u3_m_arvalid), .m_axi_arready(1'b1),
        .m_axi_rid(u3_m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
        .m_axi_rlast(u3_m_rlast), .m_axi_rvalid(u3_m_rvalid), .m_axi_rready(u3_m_rready),
        .dfx_cfg0(32'd0), .dfx_sta0(u3_dfx_sta0), .dfx_sta1(u3_dfx_sta1)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            mdl_last;
    int            mdl_outs [NS];
    logic          mdl_vld;
    logic [MW-1:0] mdl_id;
    logic [AW-1:0] mdl_addr;
    logic [7:0]    mdl_len;
    int            mdl_ar [NS];
    int            mdl_rl [NS];
    int            mdl_um;

    task automatic mdl_reset();
        mdl_last = NS - 1;
        mdl_vld  = 1'b0;
        mdl_id   = '0;
        mdl_addr = '0;
        mdl_len  = '0;
        mdl_um   = 0;
        for (int k = 0; k < NS; k++) begin
            mdl_outs[k] = 0;
            mdl_ar[k]   = 0;
            mdl_rl[k]   = 0;
        end
    endtask

    // Slave that wins this cycle, or -1
    function automatic int pick();
        if (sys_rst) return -1;
        if (mdl_vld && !m_arready) return -1;
        for (int i = 1; i <= NS; i++) begin
            int c = (mdl_last + i) % NS;
            if (s_arvalid[c] && mdl_outs[c] < MO) return c;
        end
        return -1;
    endfunction

    function automatic logic exp_rready(input int ri);
        if (ri < NS) return s_rready[ri];
        return 1'b1;
    endfunction

    initial begin : mdl_proc
        int g, ri;
        bit rhs;
        mdl_reset();
        forever begin
            @(posedge sys_clk or posedge sys_rst);
            if (sys_rst) begin
                mdl_reset();
            end else begin
                g   = pick();
                ri  = int'(m_rid[MW-1:SW]);
                rhs = m_rvalid && exp_rready(ri) && m_rlast;
                if (g >= 0) begin
                    mdl_vld  = 1'b1;
                    mdl_id   = {IW'(g), arid_a[g]};
                    mdl_addr = addr_a[g];
                    mdl_len  = len_a[g];
                    mdl_last = g;
                    mdl_outs[g]++;
                end else if (m_arready) begin
                    mdl_vld = 1'b0;
                end
                if (rhs && ri < NS && mdl_outs[ri] > 0) mdl_outs[ri]--;
                if (dfx_cfg0[0]) begin
                    for (int k = 0; k < NS; k++) begin
                        mdl_ar[k] = 0;
                        mdl_rl[k] = 0;
                    end
                    mdl_um = 0;
                end else begin
                    if (g >= 0 && mdl_ar[g] < 65535) mdl_ar[g]++;
                    if (rhs && ri < NS && mdl_rl[ri] < 65535) mdl_rl[ri]++;
                    if (m_rvalid && ri >= NS && mdl_um < 65535) mdl_um++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin : cmp_proc
        int g, ri, sel;
        forever begin
            @(negedge sys_clk);
            g  = pick();
            ri = int'(m_rid[MW-1:SW]);
            chk("s_arready", 128'(s_arready), (g < 0) ? 128'd0 : (128'd1 << g));
            chk("m_arvalid", 128'(m_arvalid), 128'(mdl_vld));
            chk("m_ar_fields", {m_arid, m_araddr, m_arlen}, {mdl_id, mdl_addr, mdl_len});
            chk("m_ar_const", {m_arsize, m_arburst, m_arlock, m_arcache, m_arprot},
                {3'b110, 2'b01, 1'b0, 4'd0, 3'd0});
            chk("s_rvalid", 128'(s_rvalid), (m_rvalid && ri < NS) ? (128'd1 << ri) : 128'd0);
            chk("m_rready", 128'(m_rready), 128'(exp_rready(ri)));
            chk("s_rid", 128'(s_rid), 128'({NS{m_rid[SW-1:0]}}));
            chk("s_rdata", 128'(s_rdata), 128'({NS{m_rdata}}));
            chk("s_rresp_rlast", 128'({s_rresp, s_rlast}), 128'({{NS{m_rresp}}, {NS{m_rlast}}}));
`ifdef IPBASE_ARB_DFX_EN
            sel = int'(dfx_cfg0[6:4]);
            chk("dfx_sta0", 128'(dfx_sta0),
                (sel < NS) ? 128'({16'(mdl_ar[sel]), 16'(mdl_rl[sel])}) : 128'd0);
            chk("dfx_sta1", 128'(dfx_sta1),
                128'({8'd0, (sel < NS) ? 8'(mdl_outs[sel]) : 8'd0, 16'(mdl_um)}));
`else
            sel = 0;
            chk("dfx_sta", 128'({dfx_sta0, dfx_sta1}), 128'(sel));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic nxt();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic r_idle();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rid    = '0;
        s_rready = '0;
    endtask

    task automatic do_reset();
        s_arvalid = '0;
        m_arready = 1'b0;
        r_idle();
        sys_rst = 1'b1;
        nxt();
        nxt();
        sys_rst = 1'b0;
    endtask

    logic [3:0]    exp_g  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [MW-1:0] exp_id [5] = '{6'h08, 6'h19, 6'h2A, 6'h3B, 6'h08};
    int pulses;

    initial begin : stim
        for (int k = 0; k < NS; k++) begin
            arid_a[k] = SW'(8 + k);
            addr_a[k] = 32'h1000_0000 + AW'(k) * 32'h100;
            len_a[k]  = 8'(k + 1);
        end
        s_arvalid = '0; m_arready = 1'b0;
        m_rdata = 32'h0; m_rresp = 2'b00;
        r_idle();
        dfx_cfg0 = 32'h1;
        u3_s_arid = '0; u3_s_araddr = '0; u3_s_arlen = '0; u3_s_arvalid = '0;
        u3_s_rready = '0; u3_m_rid = '0; u3_m_rlast = 1'b0; u3_m_rvalid = 1'b0;

        // reset state
        nxt();
        s_arvalid = 4'hF;
        @(negedge sys_clk);
        chk("rst_arready", 128'(s_arready), 128'd0);
        chk("rst_arvalid", 128'({m_arvalid, m_arid}), 128'd0);
        nxt();
        dfx_cfg0 = 32'h20;
        do_reset();

        // round-robin fairness
        s_arvalid = 4'hF; m_arready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            chk("rr_grant", 128'(s_arready), 128'(exp_g[i]));
            if (i > 0) chk("rr_arid", 128'(m_arid), 128'(exp_id[i-1]));
            nxt();
        end
        s_arvalid = '0;
        @(negedge sys_clk);
        chk("rr_arid_last", 128'(m_arid), 128'(exp_id[4]));
        nxt();

        // outstanding limit on slave 1
        dfx_cfg0 = 32'h10;
        do_reset();
        s_arvalid = 4'b0010; m_arready = 1'b1;
        @(negedge sys_clk); chk("lim_g0", 128'(s_arready), 128'(4'b0010)); nxt();
        @(negedge sys_clk); chk("lim_g1", 128'(s_arready), 128'(4'b0010)); nxt();
        @(negedge sys_clk); chk("lim_block", 128'(s_arready), 128'd0); nxt();
        m_rvalid = 1'b1; m_rid = 6'h15; m_rlast = 1'b1; s_rready = 4'b0010;
        @(negedge sys_clk);
        chk("lim_block_rlast", 128'(s_arready), 128'd0);
        chk("lim_rvalid", 128'({s_rvalid, m_rready}), 128'({4'b0010, 1'b1}));
        nxt();
        r_idle();
        @(negedge sys_clk); chk("lim_regrant", 128'(s_arready), 128'(4'b0010)); nxt();
        s_arvalid = '0;

        // backpressure on the master AR port
        do_reset();
        s_arvalid = 4'b0100; m_arready = 1'b0;
        @(negedge sys_clk);
        chk("bp_first", 128'(s_arready), 128'(4'b0100));
        pulses = (s_arready != 0) ? 1 : 0;
        nxt();
        s_arvalid = 4'b1100;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            chk("bp_hold", 128'({m_arvalid, m_arid, m_araddr, m_arlen}),
                128'({1'b1, 6'h2A, 32'h1000_0200, 8'd3}));
            if (s_arready != 0) pulses++;
            nxt();
        end
        chk("bp_pulses", 128'(pulses), 128'd1);
        m_arready = 1'b1;
        @(negedge sys_clk); chk("bp_release", 128'(s_arready), 128'(4'b1000)); nxt();
        s_arvalid = '0;
        @(negedge sys_clk); chk("bp_next_id", 128'(m_arid), 128'(6'h3B)); nxt();

        // R routing
        dfx_cfg0 = 32'h50;
        m_rvalid = 1'b1; m_rid = 6'h2A; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b10;
        m_rlast = 1'b0; s_rready = 4'b0100;
        @(negedge sys_clk);
        chk("rt_rvalid", 128'(s_rvalid), 128'(4'b0100));
        chk("rt_rid2", 128'(s_rid[11:8]), 128'(4'hA));
        chk("rt_rready1", 128'(m_rready), 128'd1);
        chk("rt_rdata2", 128'({s_rdata[95:64], s_rresp[5:4]}), 128'({32'hDEAD_BEEF, 2'b10}));
        nxt();
        s_rready = 4'b1011;
        @(negedge sys_clk); chk("rt_rready0", 128'(m_rready), 128'd0); nxt();
        r_idle();
        u3_m_rid = 6'h3A; u3_m_rvalid = 1'b1; u3_m_rlast = 1'b1;
        @(negedge sys_clk);
        chk("um_rready", 128'(u3_m_rready), 128'd1);
        chk("um_rvalid", 128'(u3_s_rvalid), 128'd0);
        nxt();
        u3_m_rvalid = 1'b0;
        @(negedge sys_clk);
`ifdef IPBASE_ARB_DFX_EN
        chk("um_cnt", 128'(u3_dfx_sta1[15:0]), 128'd1);
`else
        chk("um_sta", 128'({u3_dfx_sta0, u3_dfx_sta1}), 128'd0);
`endif
        nxt();

        // simultaneous AR and RLAST for slave 0
        dfx_cfg0 = 32'h00;
        do_reset();
        s_arvalid = 4'b0001; m_arready = 1'b1;
        @(negedge sys_clk); chk("sim_g0", 128'(s_arready), 128'(4'b0001)); nxt();
        m_rvalid = 1'b1; m_rid = 6'h05; m_rlast = 1'b1; s_rready = 4'b0001;
        @(negedge sys_clk); chk("sim_both", 128'(s_arready), 128'(4'b0001)); nxt();
        r_idle();
        @(negedge sys_clk); chk("sim_g2", 128'(s_arready), 128'(4'b0001)); nxt();
        @(negedge sys_clk); chk("sim_block", 128'(s_arready), 128'd0); nxt();
        s_arvalid = '0;

        // asynchronous reset mid-stream
        do_reset();
        s_arvalid = 4'hF; m_arready = 1'b0;
        @(negedge sys_clk); chk("ar_pre", 128'(s_arready), 128'(4'b0001)); nxt();
        #2;
        sys_rst = 1'b1;
        #1;
        chk("ar_async", 128'({m_arvalid, m_arid, s_arready}), 128'd0);
        nxt();
        #2;
        sys_rst = 1'b0;
        s_arvalid = 4'b0011; m_arready = 1'b1;
        m_rvalid = 1'b1; m_rid = 6'h15; m_rlast = 1'b1; s_rready = 4'hF;
        @(negedge sys_clk); chk("ar_first", 128'(s_arready), 128'(4'b0001)); nxt();
        r_idle();
        s_arvalid = 4'b0010;
        @(negedge sys_clk); chk("ar_nounder0", 128'(s_arready), 128'(4'b0010)); nxt();
        @(negedge sys_clk); chk("ar_nounder1", 128'(s_arready), 128'(4'b0010)); nxt();
        @(negedge sys_clk); chk("ar_nounder2", 128'(s_arready), 128'd0); nxt();
        s_arvalid = '0;
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
